// File: rtl/bvh_traversal_unit.sv
// Stack-based BVH traversal engine: slab-tests node AABBs (offset by the scene position)
// against a ray and emits the primitive ranges of hit leaf children. Q16.16 Fixed3 datapath included.
package bvh_pkg;
  typedef logic signed [31:0] fixed_t;
  typedef struct packed { fixed_t x; fixed_t y; fixed_t z; } fixed3_t;
  typedef struct packed {
    fixed3_t orig;
    fixed3_t dir;
    fixed3_t inv_dir;
    fixed_t  min_t;
    fixed_t  max_t;
  } ray_t;

  localparam fixed_t FIXED_MAX = 32'sh7FFF_FFFF;
  localparam fixed_t FIXED_MIN = 32'sh8000_0000;

  function automatic fixed_t fixed_min(input fixed_t a, input fixed_t b);
    return (a < b) ? a : b;
  endfunction

  function automatic fixed_t fixed_max(input fixed_t a, input fixed_t b);
    return (a > b) ? a : b;
  endfunction

  // Full 64b product, arithmetic shift back to Q16.16, then clamp to the 32b range.
  function automatic fixed_t fixed_mul(input fixed_t a, input fixed_t b);
    logic signed [63:0] a_w, b_w, prod, shifted;
    a_w     = {{32{a[31]}}, a};
    b_w     = {{32{b[31]}}, b};
    prod    = a_w * b_w;
    shifted = prod >>> 16;
    if (shifted > 64'sh0000_0000_7FFF_FFFF) return FIXED_MAX;
    if (shifted < 64'shFFFF_FFFF_8000_0000) return FIXED_MIN;
    return shifted[31:0];
  endfunction

  function automatic fixed3_t fixed3_add(input fixed3_t a, input fixed3_t b);
    return '{x: a.x + b.x, y: a.y + b.y, z: a.z + b.z};
  endfunction

  function automatic fixed3_t fixed3_sub(input fixed3_t a, input fixed3_t b);
    return '{x: a.x - b.x, y: a.y - b.y, z: a.z - b.z};
  endfunction

  function automatic fixed3_t fixed3_mul(input fixed3_t a, input fixed3_t b);
    return '{x: fixed_mul(a.x, b.x), y: fixed_mul(a.y, b.y), z: fixed_mul(a.z, b.z)};
  endfunction
endpackage

module bvh_traversal_unit
  import bvh_pkg::*;
#(
  parameter int NODE_W      = 8,
  parameter int PRIM_W      = 8,
  parameter int NUM_W       = 4,
  parameter int STACK_DEPTH = 16
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                strobe,
  input  logic                                restart_strobe,
  input  fixed3_t                             offset,
  input  ray_t                                r,
  output logic [NODE_W-1:0]                   node_index,
  input  logic [6*32+2*NODE_W+1:0]            node,
  input  logic [1:0][PRIM_W+NUM_W-1:0]        leaf,
  output logic [1:0][PRIM_W-1:0]              start_prim,
  output logic [1:0][NUM_W-1:0]               num_prim,
  output logic                                valid,
  output logic                                finished
);
  localparam int IDX_W = $clog2(STACK_DEPTH);
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);

  typedef struct packed {
    fixed3_t           bmin;
    fixed3_t           bmax;
    logic [NODE_W-1:0] left;
    logic [NODE_W-1:0] right;
    logic              left_leaf;
    logic              right_leaf;
  } node_t;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_TEST, S_DONE} state_t;

  state_t                    r_state;
  logic [NODE_W-1:0]         r_node_index;
  logic [SP_W-1:0]           r_sp;
  logic                      r_valid;
  logic                      r_finished;
  logic [1:0][PRIM_W-1:0]    r_start_prim;
  logic [1:0][NUM_W-1:0]     r_num_prim;
  logic [NODE_W-1:0]         r_stack [STACK_DEPTH];

  node_t                     w_node;
  fixed3_t                   w_lo, w_hi;
  fixed_t                    w_tnear, w_tfar, w_max_t;
  logic                      w_hit, w_emit, w_push;
  logic [1:0]                w_is_leaf;
  logic [1:0][PRIM_W-1:0]    w_leaf_start;
  logic [1:0][NUM_W-1:0]     w_leaf_num;
  logic                      w_unused_dir;

  assign w_node    = node_t'(node);
  assign w_is_leaf = {w_node.right_leaf, w_node.left_leaf};

  // Direction travels with the ray for later stages; the slab test only needs InvDir.
  assign w_unused_dir = ^r.dir;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_leaf_start[i] = leaf[i][PRIM_W+NUM_W-1:NUM_W];
      w_leaf_num[i]   = leaf[i][NUM_W-1:0];
    end
  end

  // Slab test on the offset node bounds
  assign w_lo    = fixed3_mul(fixed3_sub(fixed3_add(w_node.bmin, offset), r.orig), r.inv_dir);
  assign w_hi    = fixed3_mul(fixed3_sub(fixed3_add(w_node.bmax, offset), r.orig), r.inv_dir);
  assign w_max_t = r.max_t[31] ? FIXED_MAX : r.max_t;
  assign w_tnear = fixed_max(fixed_max(r.min_t, fixed_min(w_lo.x, w_hi.x)),
                             fixed_max(fixed_min(w_lo.y, w_hi.y), fixed_min(w_lo.z, w_hi.z)));
  assign w_tfar  = fixed_min(fixed_min(w_max_t, fixed_max(w_lo.x, w_hi.x)),
                             fixed_min(fixed_max(w_lo.y, w_hi.y), fixed_max(w_lo.z, w_hi.z)));
  assign w_hit   = (w_tnear <= w_tfar);

  assign w_emit = (w_is_leaf[0] && (w_leaf_num[0] != '0)) ||
                  (w_is_leaf[1] && (w_leaf_num[1] != '0));

  // Right child is deferred only when both children are internal; a full stack drops it.
  assign w_push = !reset && !restart_strobe && (r_state == S_TEST) && w_hit &&
                  !w_node.left_leaf && !w_node.right_leaf && (r_sp < SP_W'(STACK_DEPTH));

  // NOTE: the stack is plain storage guarded by r_sp, so it is deliberately left without reset.
  always_ff @(posedge clk) begin
    if (w_push) r_stack[r_sp[IDX_W-1:0]] <= w_node.right;
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_node_index <= '0;
      r_sp         <= '0;
      r_valid      <= 1'b0;
      r_finished   <= 1'b0;
      r_start_prim <= '0;
      r_num_prim   <= '0;
    end else if (restart_strobe) begin
      r_state      <= S_IDLE;
      r_node_index <= '0;
      r_sp         <= '0;
      r_valid      <= 1'b0;
      r_finished   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (strobe) begin
            r_node_index <= '0;
            r_sp         <= '0;
            r_finished   <= 1'b0;
            r_state      <= S_FETCH;
          end
        end
        S_FETCH: r_state <= S_TEST;
        S_TEST: begin
          if (w_hit) begin
            for (int i = 0; i < 2; i++) begin
              if (w_is_leaf[i]) begin
                r_start_prim[i] <= w_leaf_start[i];
                r_num_prim[i]   <= w_leaf_num[i];
              end else begin
                r_num_prim[i]   <= '0;
              end
            end
            r_valid <= w_emit;
          end
          if (w_hit && !w_node.left_leaf) begin
            r_node_index <= w_node.left;
            r_state      <= S_FETCH;
            if (w_push) r_sp <= r_sp + SP_W'(1);
          end else if (w_hit && !w_node.right_leaf) begin
            r_node_index <= w_node.right;
            r_state      <= S_FETCH;
          end else if (r_sp != '0) begin
            r_node_index <= r_stack[IDX_W'(r_sp - SP_W'(1))];
            r_sp         <= r_sp - SP_W'(1);
            r_state      <= S_FETCH;
          end else begin
            r_finished   <= 1'b1;
            r_state      <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign node_index = r_node_index;
  assign start_prim = r_start_prim;
  assign num_prim   = r_num_prim;
  assign valid      = r_valid;
  assign finished   = r_finished;
endmodule

// File: tb/tb_bvh_traversal_unit.sv
// Bench for bvh_traversal_unit: sync-ROM scene model, traversal reference model and a
// per-cycle compare process, driven by directed scenes (leaf root, miss, offset, two-level, abort).
module tb_bvh_traversal_unit;
  import bvh_pkg::*;

  localparam int NODE_W = 8;
  localparam int PRIM_W = 8;
  localparam int NUM_W  = 4;
  localparam int ONE    = 65536;
  localparam int FX_MAX = 32'h7FFF_FFFF;
  localparam int FX_MIN = 32'h8000_0000;

  logic                          clk = 1'b0;
  logic                          reset = 1'b1;
  logic                          strobe = 1'b0;
  logic                          restart_strobe = 1'b0;
  fixed3_t                       tb_off;
  ray_t                          tb_r;
  logic [NODE_W-1:0]             node_index;
  logic [6*32+2*NODE_W+1:0]      tb_node;
  logic [1:0][PRIM_W+NUM_W-1:0]  tb_leaf;
  logic [1:0][PRIM_W-1:0]        start_prim;
  logic [1:0][NUM_W-1:0]         num_prim;
  logic                          valid;
  logic                          finished;

  bvh_traversal_unit #(.NODE_W(NODE_W), .PRIM_W(PRIM_W), .NUM_W(NUM_W), .STACK_DEPTH(16)) dut (
    .clk(clk), .reset(reset), .strobe(strobe), .restart_strobe(restart_strobe),
    .offset(tb_off), .r(tb_r), .node_index(node_index), .node(tb_node), .leaf(tb_leaf),
    .start_prim(start_prim), .num_prim(num_prim), .valid(valid), .finished(finished)
  );

  always #5 clk = ~clk;

  // Scene storage
  typedef struct {
    int bmin[3];
    int bmax[3];
    int left;
    int right;
    bit ll;
    bit rl;
    int s[2];
    int n[2];
  } tnode_t;
  tnode_t mem[16];

  int ray_o[3], ray_inv[3], ray_min, ray_max, off[3];

  // Expected per-cycle outputs, indexed by cycles after the strobe cycle
  typedef struct {
    bit v; bit f; bit ci; int idx;
    bit cs0; bit cs1; int s0; int n0; int s1; int n1;
  } exp_t;
  exp_t exp_q[64];
  int   n_visits;

  int n_cmp  = 0;
  int n_fail = 0;
  int mon_cyc = 0;
  int mon_last = 0;
  bit mon_en = 1'b0;

  task automatic check(input string name, input longint act, input longint expv);
    n_cmp++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, expv);
    end
  endtask

  function automatic logic [6*32+2*NODE_W+1:0] pack_node(input int i);
    return {mem[i].bmin[0], mem[i].bmin[1], mem[i].bmin[2],
            mem[i].bmax[0], mem[i].bmax[1], mem[i].bmax[2],
            NODE_W'(mem[i].left), NODE_W'(mem[i].right), mem[i].ll, mem[i].rl};
  endfunction

  function automatic logic [1:0][PRIM_W+NUM_W-1:0] pack_leaf(input int i);
    return {PRIM_W'(mem[i].s[1]), NUM_W'(mem[i].n[1]), PRIM_W'(mem[i].s[0]), NUM_W'(mem[i].n[0])};
  endfunction

  // Synchronous ROM: data for the address seen at an edge appears after that edge
  always @(posedge clk) begin
    tb_node <= pack_node(int'(node_index[3:0]));
    tb_leaf <= pack_leaf(int'(node_index[3:0]));
  end

  task automatic set_node(input int i, input int lo, input int hi, input int left, input int right,
                          input bit ll, input bit rl, input int s0, input int n0, input int s1, input int n1);
    for (int a = 0; a < 3; a++) begin
      mem[i].bmin[a] = lo;
      mem[i].bmax[a] = hi;
    end
    mem[i].left = left;  mem[i].right = right;
    mem[i].ll = ll;      mem[i].rl = rl;
    mem[i].s[0] = s0;    mem[i].n[0] = n0;
    mem[i].s[1] = s1;    mem[i].n[1] = n1;
  endtask

  task automatic clear_scene();
    for (int i = 0; i < 16; i++) set_node(i, 0, 0, 0, 0, 1'b1, 1'b1, 0, 0, 0, 0);
  endtask

  task automatic apply_inputs();
    tb_r.orig    = '{x: ray_o[0], y: ray_o[1], z: ray_o[2]};
    tb_r.dir     = '{x: 0, y: 0, z: ONE};
    tb_r.inv_dir = '{x: ray_inv[0], y: ray_inv[1], z: ray_inv[2]};
    tb_r.min_t   = ray_min;
    tb_r.max_t   = ray_max;
    tb_off       = '{x: off[0], y: off[1], z: off[2]};
  endtask

  // Reference arithmetic: Q16.16 product, floor-shifted, clamped to 32 bits
  function automatic int fmul_ref(input int a, input int b);
    longint p;
    p = (longint'(a) * longint'(b)) >>> 16;
    if (p > longint'(FX_MAX)) return FX_MAX;
    if (p < longint'(FX_MIN)) return FX_MIN;
    return int'(p);
  endfunction

  function automatic bit slab_hit(input int id);
    int tn, tf, lo, hi;
    tn = ray_min;
    tf = (ray_max < 0) ? FX_MAX : ray_max;
    for (int a = 0; a < 3; a++) begin
      lo = fmul_ref(mem[id].bmin[a] + off[a] - ray_o[a], ray_inv[a]);
      hi = fmul_ref(mem[id].bmax[a] + off[a] - ray_o[a], ray_inv[a]);
      if (lo > hi) begin int t; t = lo; lo = hi; hi = t; end
      if (lo > tn) tn = lo;
      if (hi < tf) tf = hi;
    end
    return tn <= tf;
  endfunction

  // Depth-first walk of the scene; each visit costs two cycles, results appear one cycle after test
  task automatic build_expect();
    int stk[$];
    int cur, k, c;
    bit done, do_pop;
    for (int i = 0; i < 64; i++) begin
      exp_q[i].v = 0; exp_q[i].f = 0; exp_q[i].ci = 0; exp_q[i].idx = 0;
      exp_q[i].cs0 = 0; exp_q[i].cs1 = 0;
      exp_q[i].s0 = 0; exp_q[i].n0 = 0; exp_q[i].s1 = 0; exp_q[i].n1 = 0;
    end
    cur = 0; k = 0; done = 0;
    while (!done && k < 28) begin
      exp_q[1+2*k].ci = 1; exp_q[1+2*k].idx = cur;
      exp_q[2+2*k].ci = 1; exp_q[2+2*k].idx = cur;
      do_pop = 1;
      if (slab_hit(cur)) begin
        if ((mem[cur].ll && mem[cur].n[0] != 0) || (mem[cur].rl && mem[cur].n[1] != 0)) begin
          c = 3 + 2*k;
          exp_q[c].v   = 1;
          exp_q[c].cs0 = mem[cur].ll;  exp_q[c].s0 = mem[cur].s[0];
          exp_q[c].n0  = mem[cur].ll ? mem[cur].n[0] : 0;
          exp_q[c].cs1 = mem[cur].rl;  exp_q[c].s1 = mem[cur].s[1];
          exp_q[c].n1  = mem[cur].rl ? mem[cur].n[1] : 0;
        end
        if (!mem[cur].ll) begin
          if (!mem[cur].rl && stk.size() < 16) stk.push_back(mem[cur].right);
          cur = mem[cur].left;
          do_pop = 0;
        end else if (!mem[cur].rl) begin
          cur = mem[cur].right;
          do_pop = 0;
        end
      end
      if (do_pop) begin
        if (stk.size() > 0) cur = stk.pop_back();
        else done = 1;
      end
      k++;
    end
    n_visits = k;
    for (int i = 2*k + 1; i < 64; i++) exp_q[i].f = 1;
    mon_last = 2*k + 2;
  endtask

  // Compare process: samples 1 time unit after each rising edge
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      mon_cyc++;
      if (mon_cyc <= mon_last) begin
        check($sformatf("c%0d valid", mon_cyc), valid, exp_q[mon_cyc].v);
        check($sformatf("c%0d finished", mon_cyc), finished, exp_q[mon_cyc].f);
        if (exp_q[mon_cyc].ci)
          check($sformatf("c%0d node_index", mon_cyc), node_index, exp_q[mon_cyc].idx);
        if (exp_q[mon_cyc].v) begin
          check($sformatf("c%0d num_prim0", mon_cyc), num_prim[0], exp_q[mon_cyc].n0);
          check($sformatf("c%0d num_prim1", mon_cyc), num_prim[1], exp_q[mon_cyc].n1);
          if (exp_q[mon_cyc].cs0)
            check($sformatf("c%0d start_prim0", mon_cyc), start_prim[0], exp_q[mon_cyc].s0);
          if (exp_q[mon_cyc].cs1)
            check($sformatf("c%0d start_prim1", mon_cyc), start_prim[1], exp_q[mon_cyc].s1);
        end
      end
    end
  end

  task automatic run_traversal();
    apply_inputs();
    build_expect();
    @(negedge clk);
    strobe  = 1'b1;
    mon_cyc = 0;
    mon_en  = 1'b1;
    @(negedge clk);
    strobe = 1'b0;
    repeat (mon_last) @(negedge clk);
    mon_en = 1'b0;
  endtask

  task automatic scene_leaf_root();
    clear_scene();
    set_node(0, -ONE, ONE, 0, 0, 1'b1, 1'b1, 4, 3, 10, 0);
  endtask

  task automatic scene_two_level();
    clear_scene();
    set_node(0, -ONE, ONE, 1, 2, 1'b0, 1'b0, 0, 0, 0, 0);
    set_node(1, -ONE, ONE, 0, 0, 1'b1, 1'b1, 0, 2, 8, 1);
    set_node(2, -ONE, ONE, 0, 0, 1'b1, 1'b1, 20, 4, 0, 0);
  endtask

  initial begin
    ray_o   = '{0, 0, -10*ONE};
    ray_inv = '{FX_MAX, FX_MAX, ONE};
    ray_min = 0;
    ray_max = -1;
    off     = '{0, 0, 0};
    clear_scene();
    apply_inputs();

    // T1: reset
    repeat (2) @(negedge clk);
    check("reset valid", valid, 0);
    check("reset finished", finished, 0);
    check("reset node_index", node_index, 0);
    check("reset num_prim0", num_prim[0], 0);
    check("reset num_prim1", num_prim[1], 0);
    reset = 1'b0;

    // Pin the reference arithmetic with hand-computed values
    check("pin fmul -1*max", fmul_ref(-ONE, FX_MAX), -2147483647);
    check("pin fmul sat", fmul_ref(-6*ONE, FX_MAX), FX_MIN);
    check("pin fmul 9*1", fmul_ref(9*ONE, ONE), 9*ONE);

    // T2: root hit with leaf children
    scene_leaf_root();
    run_traversal();
    check("pin T2 visits", n_visits, 1);
    check("pin T2 valid c3", exp_q[3].v, 1);
    check("pin T2 start0", exp_q[3].s0, 4);
    check("pin T2 num0", exp_q[3].n0, 3);
    check("pin T2 finished c3", exp_q[3].f, 1);

    // T3: ray shifted off the box
    ray_o[0] = 5*ONE;
    run_traversal();
    check("pin T3 no valid", exp_q[3].v, 0);
    check("pin T3 finished c3", exp_q[3].f, 1);

    // T4: offset moves the box back onto the ray
    off[0] = 5*ONE;
    run_traversal();
    check("pin T4 valid c3", exp_q[3].v, 1);

    // T5: two-level tree
    ray_o[0] = 0;
    off[0]   = 0;
    scene_two_level();
    run_traversal();
    check("pin T5 visits", n_visits, 3);
    check("pin T5 valid c5", exp_q[5].v, 1);
    check("pin T5 start1 c5", exp_q[5].s1, 8);
    check("pin T5 num0 c7", exp_q[7].n0, 4);
    check("pin T5 finished c6", exp_q[6].f, 0);
    check("pin T5 finished c7", exp_q[7].f, 1);

    // T6: abort while node 1 is under test, then repeat T5 from scratch
    @(negedge clk);
    strobe = 1'b1;
    @(negedge clk);
    strobe = 1'b0;
    repeat (3) @(negedge clk);
    restart_strobe = 1'b1;
    @(negedge clk);
    restart_strobe = 1'b0;
    check("abort valid", valid, 0);
    check("abort finished", finished, 0);
    check("abort node_index", node_index, 0);
    repeat (3) @(negedge clk);
    check("abort idle finished", finished, 0);
    check("abort idle node_index", node_index, 0);
    run_traversal();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
